lambda_inverse: RTL and testbench

- Reverse path of the reparameterisation layer: recovers normalised noise eps = (z - mean) / sqrt(var) from a latent sample z and its mean and variance.
- Used by the training/verification datapath to check sampled latents and to compute the standardised residual for the KL/log-likelihood term.
- Multi-cycle block: iterative square root followed by iterative restoring divide, with valid/ready handshakes on both sides.

---
 rtl/lambda_inverse_if.sv | 26 ++
 rtl/lambda_inverse.sv | 195 +++++++++++++++++++
 tb/tb_lambda_inverse.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lambda_inverse_if.sv
// Handshake bundle for lambda_inverse: input triple (z, mean, variance) and result side.
// The block side uses the slave modport; the producer/consumer side uses master.
interface lambda_inverse_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] z;
  logic [DATA_W-1:0] mean;
  logic [DATA_W-1:0] variance;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] eps_out;
  logic              div_zero;
  logic              sat;

  modport master (
    output in_valid, z, mean, variance, out_ready,
    input  in_ready, out_valid, eps_out, div_zero, sat
  );

  modport slave (
    input  in_valid, z, mean, variance, out_ready,
    output in_ready, out_valid, eps_out, div_zero, sat
  );
endinterface

// File: rtl/lambda_inverse.sv
// Recovers eps = (z - mean) / sqrt(var) in signed Q(DATA_W-FRAC).FRAC using a
// bit-serial square root followed by a bit-serial restoring divide.
module lambda_inverse #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic            clk,
  input  logic            reset,
  lambda_inverse_if.slave bus
);
  localparam int RAD_W      = DATA_W + FRAC;
  localparam int SQ_W       = RAD_W / 2;
  localparam int SQRT_ITERS = SQ_W;
  localparam int DIV_ITERS  = DATA_W + FRAC + 1;
  localparam int NUM_W      = DIV_ITERS;
  localparam int CNT_W      = $clog2(DIV_ITERS + 1);

  localparam logic [NUM_W-1:0]  Q_MAX   = {{(NUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [NUM_W-1:0]  Q_MIN   = Q_MAX + {{(NUM_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] EPS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] EPS_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQRT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [RAD_W-1:0]   r_rad;
  logic [SQ_W:0]      r_sq_rem;
  logic [SQ_W-1:0]    r_root;
  logic [DATA_W:0]    r_diff;
  logic [NUM_W-1:0]   r_num;
  logic [NUM_W-1:0]   r_quo;
  logic [SQ_W-1:0]    r_dv_rem;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_eps;
  logic               r_div_zero;
  logic               r_sat;

  logic [DATA_W:0]    w_diff;
  logic [DATA_W:0]    w_abs;
  logic [SQ_W+2:0]    w_sq_rem_sh;
  logic [SQ_W+2:0]    w_sq_trial;
  logic               w_sq_ge;
  logic [SQ_W:0]      w_dv_rem_sh;
  logic               w_dv_ge;
  logic [NUM_W-1:0]   w_q_next;
  logic [DATA_W-1:0]  w_eps;
  logic               w_div_zero;
  logic               w_sat;
  logic               w_sqrt_last;
  logic               w_div_last;

  // diff is one bit wider than the operands so z - mean never overflows
  assign w_diff = {bus.z[DATA_W-1], bus.z} - {bus.mean[DATA_W-1], bus.mean};
  assign w_abs  = w_diff[DATA_W] ? ((DATA_W+1)'(0) - w_diff) : w_diff;

  assign w_sq_rem_sh = {r_sq_rem, r_rad[RAD_W-1 -: 2]};
  assign w_sq_trial  = {1'b0, r_root, 2'b01};
  assign w_sq_ge     = (w_sq_rem_sh >= w_sq_trial);

  assign w_dv_rem_sh = {r_dv_rem, r_num[NUM_W-1]};
  assign w_dv_ge     = (w_dv_rem_sh >= {1'b0, r_root});
  assign w_q_next    = {r_quo[NUM_W-2:0], w_dv_ge};

  assign w_sqrt_last = (r_cnt == CNT_W'(SQRT_ITERS - 1));
  assign w_div_last  = (r_cnt == CNT_W'(DIV_ITERS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = SQRT; else w_state_nxt = IDLE;
      SQRT:    if (w_sqrt_last)   w_state_nxt = DIV;  else w_state_nxt = SQRT;
      DIV:     if (w_div_last)    w_state_nxt = DONE; else w_state_nxt = DIV;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE; else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final sign/saturation; a zero sigma forces the result to the sign of diff
  always_comb begin
    w_eps      = {DATA_W{1'b0}};
    w_div_zero = 1'b0;
    w_sat      = 1'b0;
    if (r_root == {SQ_W{1'b0}}) begin
      w_div_zero = 1'b1;
      if (r_diff == {(DATA_W+1){1'b0}}) begin
        w_eps = {DATA_W{1'b0}};
      end else if (r_diff[DATA_W]) begin
        w_eps = EPS_MIN;
        w_sat = 1'b1;
      end else begin
        w_eps = EPS_MAX;
        w_sat = 1'b1;
      end
    end else if (r_diff[DATA_W]) begin
      if (w_q_next > Q_MIN) begin
        w_eps = EPS_MIN;
        w_sat = 1'b1;
      end else begin
        w_eps = DATA_W'(0) - w_q_next[DATA_W-1:0];
      end
    end else begin
      if (w_q_next > Q_MAX) begin
        w_eps = EPS_MAX;
        w_sat = 1'b1;
      end else begin
        w_eps = w_q_next[DATA_W-1:0];
      end
    end
  end

  // Datapath: operand capture, sqrt/divide iterations and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_rad       <= {RAD_W{1'b0}};
      r_sq_rem    <= {(SQ_W+1){1'b0}};
      r_root      <= {SQ_W{1'b0}};
      r_diff      <= {(DATA_W+1){1'b0}};
      r_num       <= {NUM_W{1'b0}};
      r_quo       <= {NUM_W{1'b0}};
      r_dv_rem    <= {SQ_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_eps       <= {DATA_W{1'b0}};
      r_div_zero  <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_rad    <= {bus.variance, {FRAC{1'b0}}};
            r_sq_rem <= {(SQ_W+1){1'b0}};
            r_root   <= {SQ_W{1'b0}};
            r_diff   <= w_diff;
            r_num    <= {w_abs, {FRAC{1'b0}}};
            r_quo    <= {NUM_W{1'b0}};
            r_dv_rem <= {SQ_W{1'b0}};
          end else begin
            r_cnt <= {CNT_W{1'b0}};
          end
        end
        SQRT: begin
          r_rad    <= r_rad << 2;
          r_sq_rem <= w_sq_ge ? (SQ_W+1)'(w_sq_rem_sh - w_sq_trial) : (SQ_W+1)'(w_sq_rem_sh);
          r_root   <= {r_root[SQ_W-2:0], w_sq_ge};
          r_cnt    <= w_sqrt_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end
        DIV: begin
          r_num    <= r_num << 1;
          r_dv_rem <= w_dv_ge ? SQ_W'(w_dv_rem_sh - {1'b0, r_root}) : SQ_W'(w_dv_rem_sh);
          r_quo    <= w_q_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_div_last) begin
            r_eps      <= w_eps;
            r_div_zero <= w_div_zero;
            r_sat      <= w_sat;
            r_cnt      <= {CNT_W{1'b0}};
          end else begin
            r_eps      <= r_eps;
          end
        end
        DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.eps_out   = r_eps;
  assign bus.div_zero  = r_div_zero;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_lambda_inverse.sv
// Directed and random checks of lambda_inverse against a real-arithmetic reference model.
module tb_lambda_inverse;
  localparam int LAT = 37;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  lambda_inverse_if #(.DATA_W(16)) bus ();

  lambda_inverse #(.DATA_W(16), .FRAC(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // eps = trunc((z-mean)/sqrt(var)) with sqrt taken as floor on the Q-scaled radicand
  function automatic void model(input logic [15:0] z, input logic [15:0] m, input logic [15:0] v,
                                output logic [15:0] e, output logic dz, output logic st);
    longint d, r, s, q, sq;
    d  = longint'($signed(z)) - longint'($signed(m));
    r  = longint'(v) * 256;
    s  = longint'($floor($sqrt(real'(r))));
    while (s * s > r) s--;
    while ((s + 1) * (s + 1) <= r) s++;
    dz = 1'b0; st = 1'b0; e = 16'h0000;
    if (s == 0) begin
      dz = 1'b1;
      st = (d != 0);
      e  = (d > 0) ? 16'h7FFF : ((d < 0) ? 16'h8000 : 16'h0000);
    end else begin
      q  = ((d < 0 ? -d : d) * 256) / s;
      sq = (d < 0) ? -q : q;
      if (sq > 32767)       begin e = 16'h7FFF; st = 1'b1; end
      else if (sq < -32768) begin e = 16'h8000; st = 1'b1; end
      else                  e = 16'(sq);
    end
  endfunction

  task automatic accept(input logic [15:0] z, input logic [15:0] m, input logic [15:0] v);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    bus.z = z; bus.mean = m; bus.variance = v; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input logic [15:0] z, input logic [15:0] m, input logic [15:0] v,
                         input int hold, input bit use_exp,
                         input logic [15:0] ee, input logic edz, input logic esat);
    logic [15:0] e; logic dz, st;
    int lat = 1;
    if (use_exp) begin e = ee; dz = edz; st = esat; end
    else model(z, m, v, e, dz, st);
    @(posedge clk); #1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, LAT);
    chk("eps_out", bus.eps_out, e);
    chk("div_zero", bus.div_zero, dz);
    chk("sat", bus.sat, st);
    chk("in_ready_done", bus.in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.z = 16'($urandom); bus.variance = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_eps", bus.eps_out, e);
      chk("hold_flags", {bus.div_zero, bus.sat}, {dz, st});
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid, 1'b0);
    chk("post_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic run(input logic [15:0] z, input logic [15:0] m, input logic [15:0] v,
                     input int hold, input bit use_exp,
                     input logic [15:0] ee, input logic edz, input logic esat);
    accept(z, m, v);
    collect(z, m, v, hold, use_exp, ee, edz, esat);
  endtask

  initial begin
    logic [15:0] rz, rm, rv;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.z = 16'h0000; bus.mean = 16'h0000; bus.variance = 16'h0000;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_eps", bus.eps_out, 16'h0000);
    chk("rst_flags", {bus.div_zero, bus.sat}, 2'b00);
    @(posedge clk); #1;

    run(16'h0300, 16'h0100, 16'h0400, 0, 1'b1, 16'h0100, 1'b0, 1'b0);
    run(16'h0100, 16'h0300, 16'h0400, 0, 1'b1, 16'hFF00, 1'b0, 1'b0);
    run(16'h0100, 16'h0000, 16'h0900, 0, 1'b1, 16'h0055, 1'b0, 1'b0);
    run(16'h0100, 16'h0000, 16'h0000, 0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run(16'h0000, 16'h0100, 16'h0000, 0, 1'b1, 16'h8000, 1'b1, 1'b1);
    run(16'h0040, 16'h0040, 16'h0000, 0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run(16'h7FFF, 16'h8000, 16'h0001, 0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run(16'h8000, 16'h7FFF, 16'h0001, 0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run(16'h0500, 16'h0200, 16'h0400, 10, 1'b1, 16'h0180, 1'b0, 1'b0);

    accept(16'h0300, 16'h0100, 16'h0400);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_eps", bus.eps_out, 16'h0000);
    chk("midrst_flags", {bus.div_zero, bus.sat}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_valid", bus.out_valid, 1'b0);
    run(16'h0300, 16'h0100, 16'h0400, 0, 1'b1, 16'h0100, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rz = 16'($urandom); rm = 16'($urandom);
      case (i % 4)
        0:       rv = 16'($urandom_range(0, 15));
        1:       rv = 16'($urandom_range(256, 4096));
        default: rv = 16'($urandom);
      endcase
      if (i % 5 == 0) rz = 16'(rm + 16'($urandom_range(0, 512)) - 16'd256);
      run(rz, rm, rv, i % 3, 1'b0, 16'h0000, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
